instruction_fetch: RTL and testbench

Instruction fetch unit for the K2 core: the reading side of `instruction_memory`. It drives the combinational ROM address from a program counter and registers each returned 8-bit word into an instruction register with a valid flag. It handles stalls, jumps and end-of-program, and sits between `instruction_memory` and the decode stage.

---
 rtl/instruction_fetch.sv | 79 +++++++
 tb/tb_instruction_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the combinational ROM address from pc and
// registers each returned word with its address and a valid flag.
module instruction_fetch #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 10,
  parameter int WRAP     = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t state;
  logic   jump_legal;

  assign mem_addr   = pc;
  assign jump_legal = (jump_addr <= LAST_PC);

  // NOTE: every state element is assigned with <= so all registers update
  // together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else if (jump_en) begin
      // A jump flushes the word at the old pc, in RUN or HALT, stalled or not.
      instr_valid <= 1'b0;
      if (jump_legal) begin
        pc     <= jump_addr;
        state  <= RUN;
        halted <= 1'b0;
      end else begin
        fault  <= 1'b1;
        state  <= HALT;
        halted <= 1'b1;
      end
    end else if (state == HALT) begin
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr       <= mem_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      if (pc == LAST_PC) begin
        if (WRAP != 0) begin
          pc <= '0;
        end else begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; ROM model returns {4'hA, mem_addr}.
// One instance with WRAP=0 carries most scenarios, a second one with WRAP=1.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WRAP=0)
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = 4'h0;
  logic [3:0] mem_addr, pc, instr_pc;
  logic [7:0] mem_data, instr;
  logic       instr_valid, halted, fault;

  // Wrapping instance (WRAP=1)
  logic       rst_w = 1'b1;
  logic       stall_w = 1'b0;
  logic       jump_en_w = 1'b0;
  logic [3:0] jump_addr_w = 4'h0;
  logic [3:0] mem_addr_w, pc_w, instr_pc_w;
  logic [7:0] mem_data_w, instr_w;
  logic       instr_valid_w, halted_w, fault_w;

  int tests_run = 0;
  int tests_failed = 0;

  assign mem_data   = {4'hA, mem_addr};
  assign mem_data_w = {4'hA, mem_addr_w};

  instruction_fetch dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr), .pc(pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .fault(fault)
  );

  instruction_fetch #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst_w), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
    .stall(stall_w), .jump_en(jump_en_w), .jump_addr(jump_addr_w), .pc(pc_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .halted(halted_w), .fault(fault_w)
  );

  // Observed state packed as {halted, fault, instr_valid, pc, instr_pc, instr}
  logic [18:0] obs, obs_w;
  assign obs   = {halted, fault, instr_valid, pc, instr_pc, instr};
  assign obs_w = {halted_w, fault_w, instr_valid_w, pc_w, instr_pc_w, instr_w};

  function automatic logic [18:0] st(input logic h, input logic f, input logic v,
                                     input logic [3:0] p, input logic [3:0] ip,
                                     input logic [7:0] i);
    return {h, f, v, p, ip, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    do_reset();
    e = st(0, 0, 0, 4'h0, 4'h0, 8'h00);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL reset: got %h expected %h", obs, e);
      tests_failed++;
    end
    tests_run++;
    if (mem_addr !== 4'h0) begin
      $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
      tests_failed++;
    end
  endtask

  task automatic test_free_run();
    logic [18:0] e;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = st(i == 9, 0, 1, (i == 9) ? 4'h9 : 4'(i + 1), 4'(i), {4'hA, 4'(i)});
      tests_run++;
      if (obs !== e) begin
        $display("FAIL free_run[%0d]: got %h expected %h", i, obs, e);
        tests_failed++;
      end
      tests_run++;
      if (mem_addr !== e[15:12]) begin
        $display("FAIL free_run_mem_addr[%0d]: got %h expected %h", i, mem_addr, e[15:12]);
        tests_failed++;
      end
    end
    // Settled HALT: valid drops, last word kept; stall has no effect
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = st(1, 0, 0, 4'h9, 4'h9, 8'hA9);
      tests_run++;
      if (obs !== e) begin
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs, e);
        tests_failed++;
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_stall();
    logic [18:0] e;
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = st(0, 0, 1, 4'h4, 4'h3, 8'hA3);
      tests_run++;
      if (obs !== e) begin
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, e);
        tests_failed++;
      end
    end
    stall = 1'b0;
    for (int i = 4; i < 6; i++) begin
      tick();
      e = st(0, 0, 1, 4'(i + 1), 4'(i), {4'hA, 4'(i)});
      tests_run++;
      if (obs !== e) begin
        $display("FAIL stall_resume[%0d]: got %h expected %h", i, obs, e);
        tests_failed++;
      end
    end
  endtask

  task automatic test_jump();
    logic [18:0] e;
    do_reset();
    repeat (5) tick();
    // pc=5 now; jump with stall also asserted
    jump_en = 1'b1; jump_addr = 4'h2; stall = 1'b1;
    tick();
    jump_en = 1'b0; stall = 1'b0;
    e = st(0, 0, 0, 4'h2, 4'h4, 8'hA4);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL jump_bubble: got %h expected %h", obs, e);
      tests_failed++;
    end
    for (int i = 2; i < 4; i++) begin
      tick();
      e = st(0, 0, 1, 4'(i + 1), 4'(i), {4'hA, 4'(i)});
      tests_run++;
      if (obs !== e) begin
        $display("FAIL jump_target[%0d]: got %h expected %h", i, obs, e);
        tests_failed++;
      end
    end
  endtask

  task automatic test_jump_boundary();
    logic [18:0] e;
    do_reset();
    repeat (2) tick();
    // Highest legal target: fetch A9 then halt
    jump_en = 1'b1; jump_addr = 4'h9;
    tick();
    jump_en = 1'b0;
    e = st(0, 0, 0, 4'h9, 4'h1, 8'hA1);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL jump_last_bubble: got %h expected %h", obs, e);
      tests_failed++;
    end
    tick();
    e = st(1, 0, 1, 4'h9, 4'h9, 8'hA9);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL jump_last_word: got %h expected %h", obs, e);
      tests_failed++;
    end
    // First illegal target, from HALT
    jump_en = 1'b1; jump_addr = 4'hA;
    tick();
    jump_en = 1'b0;
    e = st(1, 1, 0, 4'h9, 4'h9, 8'hA9);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL jump_prog_len: got %h expected %h", obs, e);
      tests_failed++;
    end
  endtask

  task automatic test_illegal_jump();
    logic [18:0] e;
    do_reset();
    repeat (4) tick();
    jump_en = 1'b1; jump_addr = 4'hC;
    tick();
    jump_en = 1'b0;
    e = st(1, 1, 0, 4'h4, 4'h3, 8'hA3);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL illegal_jump: got %h expected %h", obs, e);
      tests_failed++;
    end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    tests_run++;
    if (obs !== e) begin
      $display("FAIL fault_halt_hold: got %h expected %h", obs, e);
      tests_failed++;
    end
    jump_en = 1'b1; jump_addr = 4'h1;
    tick();
    jump_en = 1'b0;
    e = st(0, 1, 0, 4'h1, 4'h3, 8'hA3);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL fault_recover_bubble: got %h expected %h", obs, e);
      tests_failed++;
    end
    tick();
    e = st(0, 1, 1, 4'h2, 4'h1, 8'hA1);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL fault_recover_word: got %h expected %h", obs, e);
      tests_failed++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = st(0, 0, 0, 4'h0, 4'h0, 8'h00);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL fault_cleared: got %h expected %h", obs, e);
      tests_failed++;
    end
  endtask

  task automatic test_wrap();
    logic [18:0] e;
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = st(0, 0, 1, 4'((i + 1) % 10), 4'(i % 10), {4'hA, 4'(i % 10)});
      tests_run++;
      if (obs_w !== e) begin
        $display("FAIL wrap[%0d]: got %h expected %h", i, obs_w, e);
        tests_failed++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [18:0] e;
    do_reset();
    repeat (7) tick();
    e = st(0, 0, 1, 4'h7, 4'h6, 8'hA6);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL pre_reset: got %h expected %h", obs, e);
      tests_failed++;
    end
    rst = 1'b1; jump_en = 1'b1; jump_addr = 4'h3; stall = 1'b1;
    tick();
    rst = 1'b0; jump_en = 1'b0; stall = 1'b0;
    e = st(0, 0, 0, 4'h0, 4'h0, 8'h00);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL reset_mid_run: got %h expected %h", obs, e);
      tests_failed++;
    end
    tick();
    e = st(0, 0, 1, 4'h1, 4'h0, 8'hA0);
    tests_run++;
    if (obs !== e) begin
      $display("FAIL reset_first_word: got %h expected %h", obs, e);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_jump_boundary();
    test_illegal_jump();
    test_wrap();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
